// File: rtl/fifo_stream_reader.sv
// Reads words from a first-word-fall-through-less FIFO (data one cycle after the read strobe)
// and presents them as a valid/ready stream through a 2-entry output buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 36,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic [DATA_WIDTH-1:0]  FIFO_RD_DATA,
    input  logic                   FIFO_EMPTY,
    input  logic                   FIFO_ALMOST_EMPTY,
    input  logic                   FIFO_UNDERFLOW,
    output logic                   FIFO_RD_EN,
    output logic [DATA_WIDTH-1:0]  M_DATA,
    output logic                   M_VALID,
    input  logic                   M_READY,
    output logic [COUNT_WIDTH-1:0] RD_COUNT,
    output logic                   UNDERFLOW_ERR,
    output logic                   BUSY
);

    if (!(DATA_WIDTH == 9 || DATA_WIDTH == 18 || DATA_WIDTH == 36)) begin : g_bad_width
        $fatal(1, "fifo_stream_reader: DATA_WIDTH must be 9, 18 or 36");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             occ_q, occ_d;
    logic                   inflight_q;
    logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   uerr_q, uerr_d;

    logic       pop;
    logic [2:0] level;
    logic       rd_en;

    // Occupancy the buffer will have once the in-flight word lands, net of this cycle's pop.
    always_comb begin
        pop   = (occ_q != 2'd0) & M_READY;
        level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en = (state_q == RUN) & ~FIFO_EMPTY & (level < 3'd2)
              & ~(inflight_q & FIFO_ALMOST_EMPTY);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ENABLE) state_d = RUN;
            RUN:     if (!ENABLE) state_d = DRAIN;
            DRAIN: begin
                if (ENABLE)
                    state_d = RUN;
                else if (occ_q == 2'd0 && !inflight_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // buf0 is always the oldest entry; a pop shifts buf1 forward.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({inflight_q, pop})
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = FIFO_RD_DATA;
                end else begin
                    buf0_d = FIFO_RD_DATA;
                end
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0)
                    buf0_d = FIFO_RD_DATA;
                else
                    buf1_d = FIFO_RD_DATA;
                occ_d = occ_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, pop};
        uerr_d  = uerr_q | FIFO_UNDERFLOW;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= '0;
            uerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            uerr_q     <= uerr_d;
        end
    end

    assign FIFO_RD_EN    = rd_en;
    assign M_DATA        = buf0_q;
    assign M_VALID       = (occ_q != 2'd0);
    assign RD_COUNT      = count_q;
    assign UNDERFLOW_ERR = uerr_q;
    assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO with lagging flags feeds the DUT,
// a monitor records delivered words, and a linear directed sequence checks each scenario.
module tb_fifo_stream_reader;

    logic        CLK = 1'b0;
    logic        RESET, ENABLE, M_READY;
    logic [35:0] FIFO_RD_DATA;
    logic        FIFO_EMPTY, FIFO_ALMOST_EMPTY, FIFO_UNDERFLOW;
    logic        FIFO_RD_EN, M_VALID, UNDERFLOW_ERR, BUSY;
    logic [35:0] M_DATA;
    logic [3:0]  RD_COUNT;

    int compared = 0;
    int mism     = 0;

    fifo_stream_reader #(.DATA_WIDTH(36), .COUNT_WIDTH(4)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ENABLE           (ENABLE),
        .FIFO_RD_DATA     (FIFO_RD_DATA),
        .FIFO_EMPTY       (FIFO_EMPTY),
        .FIFO_ALMOST_EMPTY(FIFO_ALMOST_EMPTY),
        .FIFO_UNDERFLOW   (FIFO_UNDERFLOW),
        .FIFO_RD_EN       (FIFO_RD_EN),
        .M_DATA           (M_DATA),
        .M_VALID          (M_VALID),
        .M_READY          (M_READY),
        .RD_COUNT         (RD_COUNT),
        .UNDERFLOW_ERR    (UNDERFLOW_ERR),
        .BUSY             (BUSY)
    );

    always #5 CLK = ~CLK;

    // FIFO model: word k (0-based) holds value k+1; flags lag the true count by one cycle.
    logic load_go, inj_uf;
    int   load_n;
    int   head = 0, cnt = 0, cnt_lag = 0;
    logic uf_q = 1'b0;
    logic [35:0] rd_data = '0;

    always @(posedge CLK) begin
        if (load_go) begin
            head <= 0;
            cnt  <= load_n;
        end else if (FIFO_RD_EN && cnt > 0) begin
            rd_data <= 36'(head + 1);
            head    <= head + 1;
            cnt     <= cnt - 1;
        end
        cnt_lag <= cnt;
        uf_q    <= FIFO_RD_EN && (cnt == 0) && !load_go;
    end

    assign FIFO_RD_DATA      = rd_data;
    assign FIFO_EMPTY        = (cnt_lag == 0);
    assign FIFO_ALMOST_EMPTY = (cnt_lag == 1);
    assign FIFO_UNDERFLOW    = uf_q | inj_uf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: delivered words, cycle stamps, read pulses, hold-while-stalled, no-overflow.
    logic [35:0] got[$];
    int          gotcyc[$];
    int          cyc = 0;
    int          rd_pulses = 0;
    int          outstanding = 0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_data = '0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RESET)
            outstanding <= 0;
        else
            outstanding <= outstanding + int'(FIFO_RD_EN) - int'(M_VALID && M_READY);
    end

    always @(negedge CLK) begin
        if (prev_stall) begin
            chk("hold_valid", 64'(M_VALID), 64'd1);
            chk("hold_data", 64'(M_DATA), 64'(prev_data));
        end
        if (RESET && FIFO_RD_EN) begin
            rd_pulses++;
            chk("no_overflow", 64'((outstanding - int'(M_VALID && M_READY)) < 2), 64'd1);
        end
        if (RESET && M_VALID && M_READY) begin
            got.push_back(M_DATA);
            gotcyc.push_back(cyc);
        end
        prev_stall = RESET && M_VALID && !M_READY;
        prev_data  = M_DATA;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_fifo(input int n);
        load_n  = n;
        load_go = 1'b1;
        tick();
        load_go = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        ENABLE = 1'b0;
        while (BUSY && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, 64'(BUSY), 64'd0);
    endtask

    task automatic check_seq(input string tag, input int base, input int n);
        chk({tag, "_count"}, 64'(got.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got.size())
                chk({tag, "_data"}, 64'(got[base + i]), 64'(i + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int p;
        RESET = 1'b0; ENABLE = 1'b0; M_READY = 1'b0;
        load_go = 1'b0; load_n = 0; inj_uf = 1'b0;
        repeat (3) tick();
        load_fifo(8);

        // Reset state
        @(negedge CLK);
        chk("rst_valid", 64'(M_VALID), 64'd0);
        chk("rst_data", 64'(M_DATA), 64'd0);
        chk("rst_count", 64'(RD_COUNT), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_rd_en", 64'(FIFO_RD_EN), 64'd0);
        chk("rst_uerr", 64'(UNDERFLOW_ERR), 64'd0);

        // Streaming 8 words with M_READY steady
        tick();
        RESET = 1'b1; ENABLE = 1'b1; M_READY = 1'b1;
        b = got.size();
        @(negedge CLK);
        chk("rel_rd_en", 64'(FIFO_RD_EN), 64'd0);
        chk("rel_busy", 64'(BUSY), 64'd0);
        @(negedge CLK);
        chk("t1_busy", 64'(BUSY), 64'd1);
        chk("t1_first_rd", 64'(FIFO_RD_EN), 64'd1);
        chk("t1_valid_c1", 64'(M_VALID), 64'd0);
        @(negedge CLK);
        chk("t1_valid_c2", 64'(M_VALID), 64'd0);
        @(negedge CLK);
        chk("t1_valid_c3", 64'(M_VALID), 64'd1);
        chk("t1_data_c3", 64'(M_DATA), 64'd1);
        repeat (12) @(negedge CLK);
        check_seq("t1", b, 8);
        if (got.size() >= b + 8)
            chk("t1_back2back", 64'(gotcyc[b + 7] - gotcyc[b]), 64'd7);
        chk("t1_rd_count", 64'(RD_COUNT), 64'd8);
        chk("t1_uerr", 64'(UNDERFLOW_ERR), 64'd0);

        // 8 words with M_READY toggling; RD_COUNT (4 bits) wraps 15 -> 0
        tick();
        wait_idle("t2_pre_idle");
        tick();
        load_fifo(8);
        b = got.size();
        ENABLE = 1'b1; M_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            M_READY = ~M_READY;
        end
        @(negedge CLK);
        check_seq("t2", b, 8);
        chk("t2_count_wrap", 64'(RD_COUNT), 64'd0);

        // Single word in FIFO
        tick();
        wait_idle("t3_pre_idle");
        tick();
        load_fifo(1);
        b = got.size();
        p = rd_pulses;
        ENABLE = 1'b1; M_READY = 1'b1;
        repeat (10) tick();
        @(negedge CLK);
        chk("t3_rd_pulses", 64'(rd_pulses - p), 64'd1);
        check_seq("t3", b, 1);
        chk("t3_uerr", 64'(UNDERFLOW_ERR), 64'd0);
        chk("t3_rd_count", 64'(RD_COUNT), 64'd1);

        // Stall with buffer full, then drop ENABLE while releasing M_READY
        tick();
        wait_idle("t4_pre_idle");
        tick();
        load_fifo(8);
        b = got.size();
        ENABLE = 1'b1; M_READY = 1'b0;
        repeat (8) tick();
        @(negedge CLK);
        chk("t4_stall_valid", 64'(M_VALID), 64'd1);
        chk("t4_stall_data", 64'(M_DATA), 64'd1);
        chk("t4_stall_no_rd", 64'(FIFO_RD_EN), 64'd0);
        tick();
        ENABLE = 1'b0; M_READY = 1'b1;
        @(negedge CLK);
        chk("t4_last_rd", 64'(FIFO_RD_EN), 64'd1);
        chk("t4_data_w1", 64'(M_DATA), 64'd1);
        @(negedge CLK);
        chk("t4_drain_no_rd", 64'(FIFO_RD_EN), 64'd0);
        chk("t4_data_w2", 64'(M_DATA), 64'd2);
        chk("t4_drain_busy", 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk("t4_data_w3", 64'(M_DATA), 64'd3);
        chk("t4_valid_w3", 64'(M_VALID), 64'd1);
        @(negedge CLK);
        chk("t4_empty_valid", 64'(M_VALID), 64'd0);
        chk("t4_empty_busy", 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk("t4_idle_busy", 64'(BUSY), 64'd0);
        check_seq("t4", b, 3);
        chk("t4_rd_count", 64'(RD_COUNT), 64'd4);

        // Reset while buffer holds two words (FIFO still holds words 4..8)
        tick();
        ENABLE = 1'b1; M_READY = 1'b0;
        repeat (6) tick();
        @(negedge CLK);
        chk("t5_full_valid", 64'(M_VALID), 64'd1);
        chk("t5_full_data", 64'(M_DATA), 64'd4);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("t5_rst_valid", 64'(M_VALID), 64'd0);
        chk("t5_rst_count", 64'(RD_COUNT), 64'd0);
        chk("t5_rst_busy", 64'(BUSY), 64'd0);
        chk("t5_rst_rd_en", 64'(FIFO_RD_EN), 64'd0);
        chk("t5_rst_data", 64'(M_DATA), 64'd0);
        tick();
        tick();
        RESET = 1'b1; ENABLE = 1'b0; M_READY = 1'b1;
        repeat (3) @(negedge CLK);
        chk("t5_no_capture", 64'(M_VALID), 64'd0);

        // Count up to all-ones, then one more pop wraps to zero
        tick();
        load_fifo(15);
        b = got.size();
        ENABLE = 1'b1;
        repeat (25) tick();
        @(negedge CLK);
        check_seq("t5w", b, 15);
        chk("t5_all_ones", 64'(RD_COUNT), 64'hF);
        tick();
        wait_idle("t5_pre_idle");
        tick();
        load_fifo(1);
        b = got.size();
        ENABLE = 1'b1;
        repeat (8) tick();
        @(negedge CLK);
        chk("t5_wrap", 64'(RD_COUNT), 64'd0);
        check_seq("t5z", b, 1);

        // Sticky underflow
        chk("t6_uerr_before", 64'(UNDERFLOW_ERR), 64'd0);
        tick();
        inj_uf = 1'b1;
        tick();
        inj_uf = 1'b0;
        @(negedge CLK);
        chk("t6_uerr_set", 64'(UNDERFLOW_ERR), 64'd1);
        repeat (5) @(negedge CLK);
        chk("t6_uerr_held", 64'(UNDERFLOW_ERR), 64'd1);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("t6_uerr_cleared", 64'(UNDERFLOW_ERR), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
